// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder that reuses one 4-bit ripple-carry datapath for WIDTH/4 cycles, LSB nibble first,
// with a registered carry between nibbles and valid/ready handshakes on both sides.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  logic [3:0]       nib_a_s;
  logic [3:0]       nib_b_s;
  logic [3:0]       nib_sum_s;
  logic [4:0]       chain_s;
  logic             nib_co_s;

  assign nib_a_s    = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b_s    = b_q[{idx_q, 2'b00} +: 4];
  assign chain_s[0] = c_q;
  assign nib_co_s   = chain_s[4];

  for (genvar g = 0; g < 4; g++) begin : g_fa
    full_adder u_fa (
      .a_i (nib_a_s[g]),
      .b_i (nib_b_s[g]),
      .c_i (chain_s[g]),
      .s_o (nib_sum_s[g]),
      .c_o (chain_s[g+1])
    );
  end

  // in_ready is forced low while reset is held, even though the state already reads IDLE
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = co_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          c_d     = carry_in;
          sum_d   = '0;
          co_d    = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_sum_s;
        c_d                        = nib_co_s;
        if (idx_q == LAST_IDX) begin
          co_d    = nib_co_s;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequenced wide adder that time-shares one 4-bit ripple-carry nibble datapath across WIDTH/4 cycles, one nibble per cycle, LSB nibble first.
- A registered carry links consecutive nibbles.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- The nibble datapath is four chained full_adder instances inside this block.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and >= 4; any other value is an elaboration error.
- NIBBLES, WIDTH/4, derived localparam (not overridable); number of RUN cycles.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, carry_in are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into nibble 0.
- out_valid  output  1  sum and carry_out are valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  registered result, {nibble NIBBLES-1 .. nibble 0}.
- carry_out  output  1  carry out of the top nibble.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, sum=0, carry_out=0, out_valid=0, nibble index=0, carry register=0. in_ready=0 while reset is high, 1 in the first cycle after release.
- Registers: a_reg, b_reg (WIDTH each), c_reg (1), idx (clog2(NIBBLES), minimum 1 bit), sum, carry_out, 2-bit state.
- Three-state FSM: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clk edge with in_valid & in_ready: latch a->a_reg, b->b_reg, carry_in->c_reg; set sum=0, carry_out=0, idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge: the nibble adder computes a_reg[4*idx+:4] + b_reg[4*idx+:4] + c_reg.
  - The 4-bit result is written to sum[4*idx+:4]; its carry is written to c_reg; idx increments.
  - On the edge where idx==NIBBLES-1: the carry is also written to carry_out, idx returns to 0, and state goes to DONE.
- DONE:
  - out_valid=1; sum and carry_out are stable; in_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid drops after that edge.
  - out_ready is ignored in every other state.
- Latency: the accept edge is edge k. out_valid is high in the cycle following edge k+NIBBLES (4 edges for WIDTH=16).
- Minimum accept-to-accept spacing is NIBBLES+2 cycles. There is no same-cycle result-release/accept: in_ready is 0 in DONE.
- Result: sum = (a + b + carry_in) mod 2^WIDTH; carry_out = bit WIDTH of the full (WIDTH+1)-bit sum.
- Handshake rules:
  - in_valid while in_ready=0 is ignored: no latch, no queueing.
  - Changes to a, b, carry_in after the accept edge do not affect the result.
  - out_valid, once high, stays high with sum and carry_out unchanged until it is consumed.
  - Partial sum contents during RUN are not part of the contract.
- Boundary cases:
  - NIBBLES=1: RUN lasts exactly one edge.
  - idx wrap: idx never exceeds NIBBLES-1.
  - Carry ripples across nibble boundaries only via c_reg, one nibble per cycle.
- Reset mid-operation: asserting reset in RUN or DONE immediately (asynchronously) forces all reset values. The in-flight operation is discarded and no out_valid pulse is produced.
- Simultaneous in_valid and reset: reset wins, and nothing is latched.
- busy = (state != IDLE). It is a combinational decode of the state register.

Test Plan:
- Reset: hold reset with in_valid=1 -> out_valid=0, sum=0, carry_out=0, busy=0, in_ready=0. After release, in_ready=1 and nothing has been accepted.
- Basic (WIDTH=16): a=16'h1234, b=16'h4321, carry_in=0, out_ready=1 -> out_valid exactly 4 edges after accept, sum=16'h5555, carry_out=0.
- Ripple across all nibbles: a=16'hFFFF, b=16'h0000, carry_in=1 -> sum=16'h0000, carry_out=1. Also a=16'hFFFF, b=16'hFFFF, carry_in=1 -> sum=16'hFFFF, carry_out=1.
- Backpressure and ignore: after accepting a=16'h00FF, b=16'h0001, cin=0, change a/b every cycle and pulse in_valid while busy; hold out_ready=0 for 5 cycles -> in_ready=0 throughout, and out_valid/sum=16'h0100/carry_out=0 are held stable. Raise out_ready -> back in IDLE next cycle.
- Reset mid-RUN: accept a=16'h8000, b=16'h8000; assert reset after 2 RUN edges -> immediate IDLE, all outputs 0, no out_valid. Next op a=16'h8000, b=16'h8000, cin=0 -> sum=16'h0000, carry_out=1.
- Exhaustive sweep (WIDTH=4 and WIDTH=8 builds): all a, b, and carry_in combinations, compared against a+b+carry_in -> every result matches, and latency equals NIBBLES every time.
